// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter that shares one mesh router output link, with a one-entry registered output stage.
// Optional per-input grant statistics are enabled with the MESH_ARB_STATS_EN macro.
module mesh_port_arbiter #(
  parameter int NUM_IN = 5,
  parameter int PKT_W  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req_valid,
  output logic [NUM_IN-1:0] req_ready,
  input  logic [PKT_W-1:0]  req_pkt [NUM_IN],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_pkt
`ifdef MESH_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt [NUM_IN]
`endif
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // EMPTY/FULL is carried by the output valid bit itself.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic              out_valid_r;
  logic [PKT_W-1:0]  out_pkt_r;
  logic [PTR_W-1:0]  rr_ptr_r;

  logic              can_load_s;
  logic              load_s;
  logic              gnt_found_s;
  logic [PTR_W-1:0]  gnt_idx_s;
  logic [PTR_W-1:0]  rr_next_s;

  assign out_valid = out_valid_r;
  assign out_pkt   = out_pkt_r;

  // Output stage may accept a new packet when empty or being drained this cycle.
  always_comb begin
    can_load_s = (out_valid_r == ST_EMPTY) || out_ready;
    load_s     = !rst && can_load_s && gnt_found_s;
  end

  // Round-robin search starting at rr_ptr_r, wrapping modulo NUM_IN.
  always_comb begin
    logic [PTR_W:0]   raw;
    logic [PTR_W:0]   cand;
    logic [PTR_W-1:0] idx;
    logic             hit;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    raw         = '0;
    cand        = '0;
    idx         = '0;
    hit         = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      raw         = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      cand        = (raw >= (PTR_W+1)'(NUM_IN)) ? (raw - (PTR_W+1)'(NUM_IN)) : raw;
      idx         = cand[PTR_W-1:0];
      hit         = !gnt_found_s && req_valid[idx];
      gnt_idx_s   = hit ? idx : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit;
    end
  end

  // One-hot ready toward the granted requester only.
  always_comb begin
    req_ready = '0;
    if (load_s) begin
      req_ready[gnt_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Pointer moves to the input after the winner, wrapping at the last input.
  always_comb begin
    if (gnt_idx_s == PTR_W'(NUM_IN - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = gnt_idx_s + PTR_W'(1);
    end
  end

  // Output register and round-robin pointer; a load takes priority over a plain drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= ST_EMPTY;
      out_pkt_r   <= '0;
      rr_ptr_r    <= '0;
    end else if (load_s) begin
      out_valid_r <= ST_FULL;
      out_pkt_r   <= req_pkt[gnt_idx_s];
      rr_ptr_r    <= rr_next_s;
    end else if (out_ready) begin
      out_valid_r <= ST_EMPTY;
    end
  end

`ifdef MESH_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_r [NUM_IN];

  assign grant_cnt = grant_cnt_r;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_stats
    // Saturating count of packets accepted from input gi.
    always_ff @(posedge clk) begin
      if (rst) begin
        grant_cnt_r[gi] <= '0;
      end else if (req_valid[gi] && req_ready[gi] && (grant_cnt_r[gi] != {CNT_W{1'b1}})) begin
        grant_cnt_r[gi] <= grant_cnt_r[gi] + CNT_W'(1);
      end
    end
  end
`endif

endmodule
